// File: rtl/rfphoenix_pfx_merge.sv
// rfphoenix_pfx_merge: per-thread prefix merger between fetch and decode.
// Each thread keeps one held instruction (H) waiting for a possible PFX
// postfix, and one merged output slot (O). A PFX fuses its 24-bit payload
// into the held instruction. An orphan PFX with nothing held becomes a
// faulting NOP. A held instruction with no follow-up is released after
// HOLD_MAX idle cycles. Output slots drain to decode through a round-robin
// arbiter whose grant stays put while decode stalls.
module rfphoenix_pfx_merge #(
  parameter int NTHREADS = 6,
  parameter int HOLD_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_v,
  input  logic [3:0]          in_thread,
  input  logic [31:0]         in_ip,
  input  logic [39:0]         in_insn,
  input  logic [11:0]         in_cause,
  input  logic [2:0]          in_sp_sel,
  output logic                in_rdy,
  input  logic [NTHREADS-1:0] flush,
  output logic                out_v,
  output logic [3:0]          out_thread,
  output logic [111:0]        out_ifb,
  input  logic                out_rdy
);

  localparam int          CW       = $clog2(HOLD_MAX) + 1;
  localparam logic [39:0] NOP_INSN = 40'h00_0000_003F;
  localparam logic [11:0] FLT_PFX  = 12'h0C8;

  // Per-thread state flattened to 16 entries (the full in_thread range);
  // entries at or above NTHREADS are tied off so out-of-range ids are inert.
  logic [15:0]  o_v_vec;
  logic [110:0] o_dat [16];
  logic [15:0]  flush16;
  logic [15:0]  elig;

  logic         in_acc;
  logic         in_pfx;
  logic         xfer;
  logic         grant_found;
  logic [3:0]   grant_idx;
  logic [4:0]   cand_sum;
  logic [3:0]   p_reg;
  logic [3:0]   p_next;
  logic         lock_v_reg;
  logic [3:0]   lock_thr_reg;

  // Widen flush to the 16-entry view used by the arbiter.
  always_comb begin
    flush16 = '0;
    flush16[NTHREADS-1:0] = flush;
  end

  // Readiness depends only on the thread's registered output slot.
  assign in_rdy = ({28'd0, in_thread} < 32'(NTHREADS)) && !o_v_vec[in_thread];
  assign in_acc = in_v && in_rdy;
  assign in_pfx = (in_insn[5:0] == 6'h01);
  assign xfer   = out_v && out_rdy;

  for (genvar gi = 0; gi < 16; gi++) begin : g_thr
    if (gi < NTHREADS) begin : g_live
      // h_dat_reg = {ip[31:0], insn[39:0], cause[11:0], sp_sel[2:0]}
      logic          h_v_reg;
      logic [86:0]   h_dat_reg;
      logic          o_v_reg;
      logic [110:0]  o_dat_reg;
      logic [CW-1:0] c_reg;
      logic          acc;

      assign acc = in_acc && (in_thread == 4'(gi));

      // Hold/output/idle-counter update; flush wins over everything else.
      always_ff @(posedge clk) begin
        if (rst || flush[gi]) begin
          h_v_reg <= 1'b0;
          o_v_reg <= 1'b0;
          c_reg   <= '0;
        end else begin
          if (xfer && (grant_idx == 4'(gi)))
            o_v_reg <= 1'b0;
          if (acc) begin
            c_reg <= '0;
            if (!in_pfx) begin
              // Held instruction leaves unprefixed; newcomer takes its place.
              if (h_v_reg) begin
                o_v_reg   <= 1'b1;
                o_dat_reg <= {h_dat_reg[86:15], 24'd0, h_dat_reg[14:0]};
              end
              h_v_reg   <= 1'b1;
              h_dat_reg <= {in_ip, in_insn, in_cause, in_sp_sel};
            end else begin
              o_v_reg <= 1'b1;
              h_v_reg <= 1'b0;
              if (h_v_reg)
                o_dat_reg <= {h_dat_reg[86:15], in_insn[23:0], h_dat_reg[14:0]};
              else
                o_dat_reg <= {in_ip, NOP_INSN, in_insn[23:0], FLT_PFX, in_sp_sel};
            end
          end else if (h_v_reg) begin
            if ((c_reg == CW'(HOLD_MAX)) && !o_v_reg) begin
              o_v_reg   <= 1'b1;
              o_dat_reg <= {h_dat_reg[86:15], 24'd0, h_dat_reg[14:0]};
              h_v_reg   <= 1'b0;
              c_reg     <= '0;
            end else if (c_reg != CW'(HOLD_MAX)) begin
              c_reg <= c_reg + CW'(1);
            end
          end
        end
      end

      assign o_v_vec[gi] = o_v_reg;
      assign o_dat[gi]   = o_dat_reg;
    end else begin : g_tie
      assign o_v_vec[gi] = 1'b0;
      assign o_dat[gi]   = '0;
    end
  end

  // Arbiter: a grant held over a stall keeps priority; otherwise the first
  // eligible thread at or after the pointer (scanned backwards so the
  // smallest offset wins).
  always_comb begin
    elig        = o_v_vec & ~flush16;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int k = NTHREADS - 1; k >= 0; k--) begin
      cand_sum = {1'b0, p_reg} + 5'(k);
      if (cand_sum >= 5'(NTHREADS))
        cand_sum = cand_sum - 5'(NTHREADS);
      if (elig[cand_sum[3:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[3:0];
      end
    end
    if (lock_v_reg && elig[lock_thr_reg]) begin
      grant_found = 1'b1;
      grant_idx   = lock_thr_reg;
    end
  end

  // Pointer advances past the thread that just transferred.
  always_comb begin
    p_next = p_reg;
    if (xfer)
      p_next = (grant_idx == 4'(NTHREADS - 1)) ? 4'd0 : grant_idx + 4'd1;
  end

  // Round-robin pointer and stall lock registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg        <= '0;
      lock_v_reg   <= 1'b0;
      lock_thr_reg <= '0;
    end else begin
      p_reg        <= p_next;
      lock_v_reg   <= out_v && !out_rdy;
      lock_thr_reg <= grant_idx;
    end
  end

  assign out_v      = grant_found;
  assign out_thread = grant_found ? grant_idx : 4'd0;
  assign out_ifb    = grant_found ? {1'b1, o_dat[grant_idx]} : 112'd0;

endmodule

// File: tb/tb_rfphoenix_pfx_merge.sv
// Testbench for rfphoenix_pfx_merge: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_rfphoenix_pfx_merge;

  localparam int          NT       = 6;
  localparam int          HM       = 8;
  localparam logic [39:0] NOP_INSN = 40'h00_0000_003F;
  localparam logic [39:0] ADDI     = 40'h00_0000_0013;
  localparam logic [39:0] PFXI     = 40'h00_0012_3401;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_v;
  logic [3:0]    in_thread;
  logic [31:0]   in_ip;
  logic [39:0]   in_insn;
  logic [11:0]   in_cause;
  logic [2:0]    in_sp_sel;
  logic          in_rdy;
  logic [NT-1:0] flush;
  logic          out_v;
  logic [3:0]    out_thread;
  logic [111:0]  out_ifb;
  logic          out_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  rfphoenix_pfx_merge #(.NTHREADS(NT), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .in_v(in_v), .in_thread(in_thread), .in_ip(in_ip),
    .in_insn(in_insn), .in_cause(in_cause), .in_sp_sel(in_sp_sel), .in_rdy(in_rdy),
    .flush(flush), .out_v(out_v), .out_thread(out_thread), .out_ifb(out_ifb),
    .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [111:0] mk(input logic [31:0] ip, input logic [39:0] insn,
                                      input logic [23:0] pfx, input logic [11:0] cause,
                                      input logic [2:0] sp);
    return {1'b1, ip, insn, pfx, cause, sp};
  endfunction

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] thr, input logic [31:0] ip,
                       input logic [39:0] insn, input logic [11:0] cause, input logic [2:0] sp,
                       input logic [NT-1:0] fl, input logic ordy);
    in_v = v; in_thread = thr; in_ip = ip; in_insn = insn;
    in_cause = cause; in_sp_sel = sp; flush = fl; out_rdy = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [3:0]    thr;
    logic [31:0]   ip;
    logic [39:0]   insn;
    logic [11:0]   cause;
    logic [2:0]    sp;
    logic [NT-1:0] fl;
    logic          e_v;
    logic          e_rdy;
    logic [3:0]    e_thr;
    logic [111:0]  e_ifb;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  // ---------------- reference model state ----------------
  logic          m_hv    [NT];
  logic [31:0]   m_hip   [NT];
  logic [39:0]   m_hinsn [NT];
  logic [11:0]   m_hcause[NT];
  logic [2:0]    m_hsp   [NT];
  logic          m_ov    [NT];
  logic [110:0]  m_odat  [NT];
  int            m_cnt   [NT];
  int            m_p;
  bit            m_stall;
  int            m_last;
  bit            e_v;
  int            e_grant;

  task automatic m_reset();
    for (int t = 0; t < NT; t++) begin
      m_hv[t] = 1'b0; m_ov[t] = 1'b0; m_cnt[t] = 0;
    end
    m_p = 0; m_stall = 0; m_last = 0;
  endtask

  // Which thread decode sees this cycle, given the current inputs.
  task automatic m_comb();
    e_v = 0; e_grant = 0;
    if (m_stall && m_ov[m_last] && !flush[m_last]) begin
      e_v = 1; e_grant = m_last;
    end else begin
      for (int k = 0; k < NT; k++) begin
        int t;
        t = (m_p + k) % NT;
        if (!e_v && m_ov[t] && !flush[t]) begin
          e_v = 1; e_grant = t;
        end
      end
    end
  endtask

  // State after the clock edge, applying the merge rules thread by thread.
  task automatic m_seq();
    bit acc, pf, ov_pre;
    if (rst) begin
      m_reset();
      return;
    end
    acc = in_v && !m_ov[in_thread];
    pf  = (in_insn[5:0] == 6'h01);
    for (int t = 0; t < NT; t++) begin
      ov_pre = m_ov[t];
      if (flush[t]) begin
        m_hv[t] = 0; m_ov[t] = 0; m_cnt[t] = 0;
        continue;
      end
      if (e_v && out_rdy && e_grant == t) m_ov[t] = 0;
      if (acc && int'(in_thread) == t) begin
        m_cnt[t] = 0;
        if (!pf) begin
          if (m_hv[t]) begin
            m_ov[t] = 1;
            m_odat[t] = {m_hip[t], m_hinsn[t], 24'd0, m_hcause[t], m_hsp[t]};
          end
          m_hv[t] = 1; m_hip[t] = in_ip; m_hinsn[t] = in_insn;
          m_hcause[t] = in_cause; m_hsp[t] = in_sp_sel;
        end else begin
          m_ov[t] = 1;
          if (m_hv[t])
            m_odat[t] = {m_hip[t], m_hinsn[t], in_insn[23:0], m_hcause[t], m_hsp[t]};
          else
            m_odat[t] = {in_ip, NOP_INSN, in_insn[23:0], 12'h0C8, in_sp_sel};
          m_hv[t] = 0;
        end
      end else if (m_hv[t]) begin
        if (m_cnt[t] == HM && !ov_pre) begin
          m_ov[t] = 1;
          m_odat[t] = {m_hip[t], m_hinsn[t], 24'd0, m_hcause[t], m_hsp[t]};
          m_hv[t] = 0; m_cnt[t] = 0;
        end else if (m_cnt[t] < HM) begin
          m_cnt[t]++;
        end
      end
    end
    if (e_v && out_rdy) m_p = (e_grant + 1) % NT;
    m_stall = e_v && !out_rdy;
    m_last  = e_grant;
  endtask

  initial begin
    int n_seen;
    logic [111:0] held;
    logic [3:0]   rr_thr [3];
    logic [31:0]  rr_ip  [3];
    logic [63:0]  r;

    // Table contents: threads 2 (merge), 3 (orphan), 1 (flush on PFX).
    for (int i = 0; i < NV; i++)
      vecs[i] = '{1'b0, 4'd1, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b0, 1'b1, 4'd0, 112'd0};
    vecs[0] = '{1'b1, 4'd2, 32'h100, ADDI, 12'h0, 3'd1, '0, 1'b0, 1'b1, 4'd0, 112'd0};
    vecs[1] = '{1'b1, 4'd2, 32'h104, PFXI, 12'h0, 3'd1, '0, 1'b0, 1'b1, 4'd0, 112'd0};
    vecs[2] = '{1'b0, 4'd2, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b1, 1'b0, 4'd2,
                mk(32'h100, ADDI, 24'h123401, 12'h000, 3'd1)};
    vecs[3] = '{1'b0, 4'd2, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b0, 1'b1, 4'd0, 112'd0};
    vecs[4] = '{1'b1, 4'd3, 32'h300, PFXI, 12'h005, 3'd3, '0, 1'b0, 1'b1, 4'd0, 112'd0};
    vecs[5] = '{1'b0, 4'd3, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b1, 1'b0, 4'd3,
                mk(32'h300, NOP_INSN, 24'h123401, 12'h0C8, 3'd3)};
    vecs[6] = '{1'b0, 4'd3, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b0, 1'b1, 4'd0, 112'd0};
    vecs[7] = '{1'b1, 4'd1, 32'h180, ADDI, 12'h0, 3'd2, '0, 1'b0, 1'b1, 4'd0, 112'd0};
    vecs[8] = '{1'b1, 4'd1, 32'h184, PFXI, 12'h0, 3'd2, 6'b000010, 1'b0, 1'b1, 4'd0, 112'd0};

    // Reset and post-reset state.
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b1);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_v", 112'(out_v), 112'd0);
    chk("reset out_thread", 112'(out_thread), 112'd0);
    chk("reset out_ifb", out_ifb, 112'd0);
    chk("reset in_rdy", 112'(in_rdy), 112'd1);
    $display("[TB] reset checked");
    next_cycle();

    // Table-driven vectors, one cycle per row, decode always ready.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].thr, vecs[i].ip, vecs[i].insn, vecs[i].cause,
            vecs[i].sp, vecs[i].fl, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d out_v", i), 112'(out_v), 112'(vecs[i].e_v));
      chk($sformatf("vec%0d in_rdy", i), 112'(in_rdy), 112'(vecs[i].e_rdy));
      if (vecs[i].e_v) begin
        chk($sformatf("vec%0d out_thread", i), 112'(out_thread), 112'(vecs[i].e_thr));
        chk($sformatf("vec%0d out_ifb", i), out_ifb, vecs[i].e_ifb);
      end
      $display("[TB] vec %0d thr %0d in_v %0d out_v %0d out_thread %0d", i, vecs[i].thr,
               vecs[i].v, out_v, out_thread);
      next_cycle();
    end

    // Timeout: two ADDIs on thread 0, second released after idle cycles.
    drive(1'b1, 4'd0, 32'h200, ADDI, 12'h0, 3'd2, '0, 1'b1);
    next_cycle();
    drive(1'b1, 4'd0, 32'h204, ADDI, 12'h0, 3'd2, '0, 1'b1);
    next_cycle();
    drive(1'b0, 4'd0, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b1);
    n_seen = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("timeout first out_v", 112'(out_v), 112'd1);
        chk("timeout first ifb", out_ifb, mk(32'h200, ADDI, 24'd0, 12'h0, 3'd2));
      end else if (n_seen == 0 && out_v) begin
        n_seen = n;
        chk("timeout second ifb", out_ifb, mk(32'h204, ADDI, 24'd0, 12'h0, 3'd2));
      end
      next_cycle();
    end
    chk("timeout release cycle", 112'(n_seen), 112'd10);
    $display("[TB] timeout release seen at cycle %0d", n_seen);

    // Round robin: move pointer to 2, load 4,5,1 while stalled, then drain.
    drive(1'b1, 4'd1, 32'h410, PFXI, 12'h0, 3'd0, '0, 1'b1);
    next_cycle();
    drive(1'b0, 4'd1, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b1);
    @(negedge clk);
    chk("rr setup out_thread", 112'(out_thread), 112'd1);
    next_cycle();
    drive(1'b1, 4'd4, 32'h440, PFXI, 12'h0, 3'd4, '0, 1'b0);
    next_cycle();
    drive(1'b1, 4'd5, 32'h450, PFXI, 12'h0, 3'd5, '0, 1'b0);
    next_cycle();
    drive(1'b1, 4'd1, 32'h411, PFXI, 12'h0, 3'd1, '0, 1'b0);
    next_cycle();
    rr_thr = '{4'd4, 4'd5, 4'd1};
    rr_ip  = '{32'h440, 32'h450, 32'h411};
    drive(1'b0, 4'd0, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d out_thread", i), 112'(out_thread), 112'(rr_thr[i]));
      chk($sformatf("rr%0d out_ip", i), 112'(out_ifb[110:79]), 112'(rr_ip[i]));
      $display("[TB] rr grant %0d thread %0d", i, out_thread);
      next_cycle();
    end

    // Stall on thread 0 for 3 cycles while thread 3 becomes eligible.
    held = mk(32'h500, NOP_INSN, 24'h123401, 12'h0C8, 3'd6);
    drive(1'b1, 4'd0, 32'h500, PFXI, 12'h0, 3'd6, '0, 1'b0);
    next_cycle();
    for (int d = 1; d <= 4; d++) begin
      if (d == 2) drive(1'b1, 4'd3, 32'h530, PFXI, 12'h0, 3'd3, '0, 1'b0);
      else        drive(1'b0, 4'd0, 32'h0, 40'h0, 12'h0, 3'd0, '0, (d == 4));
      @(negedge clk);
      chk($sformatf("stall%0d out_thread", d), 112'(out_thread), 112'd0);
      chk($sformatf("stall%0d out_ifb", d), out_ifb, held);
      if (d != 2) chk($sformatf("stall%0d in_rdy", d), 112'(in_rdy), 112'd0);
      $display("[TB] stall cycle %0d out_thread %0d in_rdy %0d", d, out_thread, in_rdy);
      next_cycle();
    end
    drive(1'b0, 4'd0, 32'h0, 40'h0, 12'h0, 3'd0, '0, 1'b0);
    @(negedge clk);
    chk("post xfer in_rdy", 112'(in_rdy), 112'd1);
    chk("post xfer out_thread", 112'(out_thread), 112'd3);
    next_cycle();
    out_rdy = 1'b1;
    next_cycle();

    // Randomized traffic against the model, with one mid-run reset.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_v      = ($urandom_range(0, 99) < (((cyc / 100) % 2) ? 15 : 60));
      in_thread = 4'($urandom_range(0, NT - 1));
      in_ip     = $urandom;
      r         = {$urandom, $urandom};
      in_insn   = r[39:0];
      if ($urandom_range(0, 99) < 35) in_insn[5:0] = 6'h01;
      else if (in_insn[5:0] == 6'h01) in_insn[5:0] = 6'h02;
      in_cause  = 12'($urandom);
      in_sp_sel = 3'($urandom);
      flush     = ($urandom_range(0, 9) == 0) ? NT'(1 << $urandom_range(0, NT - 1)) : '0;
      out_rdy   = ($urandom_range(0, 3) != 0);
      rst       = (cyc == 400);
      @(negedge clk);
      m_comb();
      chk($sformatf("rnd%0d out_v", cyc), 112'(out_v), 112'(e_v));
      chk($sformatf("rnd%0d in_rdy", cyc), 112'(in_rdy), 112'(!m_ov[in_thread]));
      if (e_v) begin
        chk($sformatf("rnd%0d out_thread", cyc), 112'(out_thread), 112'(e_grant));
        chk($sformatf("rnd%0d out_ifb", cyc), out_ifb, {1'b1, m_odat[e_grant]});
        if (out_rdy)
          $display("[TB] rnd %0d xfer thread %0d ip %h pfx %h", cyc, e_grant,
                   m_odat[e_grant][110:79], m_odat[e_grant][38:15]);
      end
      @(posedge clk);
      m_seq();
      #1;
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
